// File: rtl/piso_serializer_pkg.sv
// Shared definitions for the parallel-in/serial-out loader.
// States are plain localparam constants so older tools can read them.
package piso_serializer_pkg;

  // Word width shared with the 4-tap SISO stage downstream.
  localparam int unsigned DefaultWidth = 4;

  // Bit-counter width for the default word width.
  localparam int unsigned DefaultCntW = $clog2(DefaultWidth + 1);

  typedef logic [1:0] state_t;

  localparam state_t StIdle   = 2'd0;
  localparam state_t StShift  = 2'd1;
  localparam state_t StParity = 2'd2;

endpackage

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out loader feeding the serial input of the SISO shift register.
// Accepts a word on a valid/ready handshake and emits it one bit per clock.
// Words accepted back to back form a gap-free bitstream.
// Build option: define PISO_PARITY_EN to append an even-parity bit to every frame.
module piso_serializer
  import piso_serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = DefaultWidth,
  parameter int unsigned MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             busy,
  output logic             done
);

  localparam int unsigned      CNT_W   = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] shreg_shifted;
  logic             last_data;
  logic             last_bit;
  logic             accept;
  logic             data_bit;

  assign last_data = (state_q == StShift) && (cnt_q == LastCnt);

`ifdef PISO_PARITY_EN
  logic parity_q, parity_d;
  // With parity the frame ends on the parity cycle, not on the last data bit.
  assign last_bit = (state_q == StParity);
`else
  assign last_bit = last_data;
`endif

  // Ready depends only on registered state so din_valid never loops back into it.
  assign din_ready  = (state_q == StIdle) || last_bit;
  assign accept     = din_valid && din_ready;
  assign busy       = (state_q != StIdle);
  assign sout_valid = busy;
  assign done       = last_bit;

  // The bit on the wire is always at the outgoing end of the shift register.
  assign data_bit      = (MSB_FIRST != 0) ? shreg_q[WIDTH-1] : shreg_q[0];
  assign shreg_shifted = (MSB_FIRST != 0) ? {shreg_q[WIDTH-2:0], 1'b0}
                                          : {1'b0, shreg_q[WIDTH-1:1]};

  // Serial output: data bit while shifting, parity bit in its own cycle, 0 when idle.
  always_comb begin
    sout = 1'b0;
    if (state_q == StShift) begin
      sout = data_bit;
    end
`ifdef PISO_PARITY_EN
    else if (state_q == StParity) begin
      sout = parity_q;
    end
`endif
  end

  // Next-state logic: an accept always (re)starts a frame, otherwise advance the frame.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    shreg_d = shreg_q;
`ifdef PISO_PARITY_EN
    parity_d = parity_q;
`endif
    if (accept) begin
      state_d = StShift;
      cnt_d   = '0;
      shreg_d = din;
`ifdef PISO_PARITY_EN
      parity_d = ^din;
`endif
    end else begin
      case (state_q)
        StShift: begin
          shreg_d = shreg_shifted;
          if (last_data) begin
            cnt_d = '0;
`ifdef PISO_PARITY_EN
            state_d = StParity;
`else
            state_d = StIdle;
`endif
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with synchronous reset; reset beats a simultaneous din_valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      shreg_q <= '0;
`ifdef PISO_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
`ifdef PISO_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

endmodule
